// File: rtl/menu_control.sv
// Menu / countdown controller for the racing game front end.
// Turns keyboard levels into single presses, walks the menu screens,
// runs the 3-2-1 countdown on vblank edges and fires race_start.
// The menu_state output changes only on vblank edges, so the text
// overlay never switches screens partway through a frame.
module menu_control #(
  parameter int FRAMES_PER_COUNT = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_enter,
  input  logic       key_esc,
  input  logic       vblnk_in,
  input  logic       race_done,
  output logic [2:0] menu_state,
  output logic [1:0] car_sel,
  output logic [1:0] countdown,
  output logic       race_start
);

  typedef enum logic [2:0] {
    MAIN_PLAY   = 3'd0,
    MAIN_CARS   = 3'd1,
    MAIN_HELP   = 3'd2,
    CAR_SELECT  = 3'd3,
    HELP_SCREEN = 3'd4,
    COUNTDOWN   = 3'd5,
    IN_GAME     = 3'd6,
    RESULT      = 3'd7
  } state_t;

  localparam logic [7:0] FC_LAST = 8'(FRAMES_PER_COUNT - 1);

  state_t     state;
  logic [7:0] frame_cnt;
  logic [3:0] key_q;      // {esc, enter, up, down} delayed one cycle
  logic [3:0] key_now;
  logic [3:0] key_rise;
  logic       vblnk_q;
  logic       vb_edge;
  logic       p_esc, p_enter, p_up, p_down;

  assign key_now  = {key_esc, key_enter, key_up, key_down};
  assign key_rise = key_now & ~key_q;
  assign vb_edge  = vblnk_in & ~vblnk_q;

  // Only the highest-priority press survives: esc > enter > up > down.
  always_comb begin
    p_esc   = key_rise[3];
    p_enter = key_rise[2] & ~key_rise[3];
    p_up    = key_rise[1] & ~(|key_rise[3:2]);
    p_down  = key_rise[0] & ~(|key_rise[3:1]);
  end

  // Edge-detect registers; reset high so a key held through reset is not a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q   <= 4'hF;
      vblnk_q <= 1'b1;
    end else begin
      key_q   <= key_now;
      vblnk_q <= vblnk_in;
    end
  end

  // Main screen FSM with car selection, countdown and race_start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= MAIN_PLAY;
      car_sel    <= 2'd0;
      countdown  <= 2'd0;
      race_start <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      race_start <= 1'b0;
      case (state)
        MAIN_PLAY: begin
          if (p_down)       state <= MAIN_CARS;
          else if (p_up)    state <= MAIN_HELP;
          else if (p_enter) begin
            state     <= COUNTDOWN;
            countdown <= 2'd3;
            frame_cnt <= 8'd0;
          end
        end
        MAIN_CARS: begin
          if (p_down)       state <= MAIN_HELP;
          else if (p_up)    state <= MAIN_PLAY;
          else if (p_enter) state <= CAR_SELECT;
        end
        MAIN_HELP: begin
          if (p_down)       state <= MAIN_PLAY;
          else if (p_up)    state <= MAIN_CARS;
          else if (p_enter) state <= HELP_SCREEN;
        end
        CAR_SELECT: begin
          if (p_up)                  car_sel <= car_sel + 2'd1;
          else if (p_down)           car_sel <= car_sel - 2'd1;
          else if (p_enter || p_esc) state   <= MAIN_CARS;
        end
        HELP_SCREEN: begin
          if (p_enter || p_esc) state <= MAIN_HELP;
        end
        COUNTDOWN: begin
          if (p_esc) begin
            state     <= MAIN_PLAY;
            countdown <= 2'd0;
            frame_cnt <= 8'd0;
          end else if (vb_edge) begin
            if (frame_cnt == FC_LAST) begin
              frame_cnt <= 8'd0;
              if (countdown == 2'd1) begin
                state      <= IN_GAME;
                countdown  <= 2'd0;
                race_start <= 1'b1;
              end else begin
                countdown <= countdown - 2'd1;
              end
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        IN_GAME: begin
          // A finished race outranks a simultaneous quit.
          if (race_done)  state <= RESULT;
          else if (p_esc) state <= MAIN_PLAY;
        end
        RESULT: begin
          if (p_enter || p_esc) state <= MAIN_PLAY;
        end
        default: state <= MAIN_PLAY;
      endcase
    end
  end

  // Publish the screen code once per frame, at the vblank edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          menu_state <= 3'd0;
    else if (vb_edge) menu_state <= state;
  end

endmodule

// File: tb/tb_menu_control.sv
// Directed bench for menu_control with a queue-based scoreboard:
// stimulus pushes hand-computed expectations, a monitor on the falling
// edge pops and compares them against the DUT outputs.
module tb_menu_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_up = 1'b0, key_down = 1'b0, key_enter = 1'b0, key_esc = 1'b0;
  logic       vblnk_in = 1'b0;
  logic       race_done = 1'b0;
  logic [2:0] menu_state;
  logic [1:0] car_sel;
  logic [1:0] countdown;
  logic       race_start;

  typedef struct {
    string nm;
    int    ms;
    int    cs;
    int    cd;
    int    rs;
    int    rsn;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   rs_seen = 0;

  menu_control #(.FRAMES_PER_COUNT(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_up     (key_up),
    .key_down   (key_down),
    .key_enter  (key_enter),
    .key_esc    (key_esc),
    .vblnk_in   (vblnk_in),
    .race_done  (race_done),
    .menu_state (menu_state),
    .car_sel    (car_sel),
    .countdown  (countdown),
    .race_start (race_start)
  );

  always #5 clk = ~clk;

  // Monitor: count race_start cycles, then check the pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (race_start === 1'b1) rs_seen++;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_chk++;
        if (menu_state !== e.ms[2:0] || car_sel !== e.cs[1:0] || countdown !== e.cd[1:0] ||
            race_start !== e.rs[0] || rs_seen != e.rsn) begin
          n_fail++;
          $display("FAIL %s: got ms=%0d cs=%0d cd=%0d rs=%0b pulses=%0d, want ms=%0d cs=%0d cd=%0d rs=%0d pulses=%0d",
                   e.nm, menu_state, car_sel, countdown, race_start, rs_seen,
                   e.ms, e.cs, e.cd, e.rs, e.rsn);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Called just after a rising edge; returns after the monitor has checked.
  task automatic chk(input string nm, input int ms, input int cs, input int cd,
                     input int rs, input int rsn);
    exp_t e;
    e.nm = nm; e.ms = ms; e.cs = cs; e.cd = cd; e.rs = rs; e.rsn = rsn;
    q.push_back(e);
    @(negedge clk); #1;
  endtask

  // k: 0 down, 1 up, 2 enter, 3 esc
  task automatic press(input int k);
    case (k)
      0: key_down  = 1'b1;
      1: key_up    = 1'b1;
      2: key_enter = 1'b1;
      default: key_esc = 1'b1;
    endcase
    tick();
    key_down = 1'b0; key_up = 1'b0; key_enter = 1'b0; key_esc = 1'b0;
    tick();
  endtask

  task automatic vbl();
    vblnk_in = 1'b1;
    tick();
    vblnk_in = 1'b0;
    tick();
  endtask

  // Six vblank edges from countdown entry; digits after each edge 3,2,2,1,1,0.
  task automatic countdown_run(input int cs, input int rsn0);
    int cd_after[6] = '{3, 2, 2, 1, 1, 0};
    for (int i = 0; i < 6; i++) begin
      vblnk_in = 1'b1;
      tick();
      vblnk_in = 1'b0;
      chk($sformatf("cd_edge%0d", i + 1), 5, cs, cd_after[i], (i == 5) ? 1 : 0,
          (i == 5) ? rsn0 + 1 : rsn0);
      tick();
    end
    chk("race_start_one_cycle", 5, cs, 0, 0, rsn0 + 1);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("reset_state", 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick(); tick();

    // Navigation
    press(0); vbl(); chk("nav_down1", 1, 0, 0, 0, 0);
    press(0); vbl(); chk("nav_down2", 2, 0, 0, 0, 0);
    press(1); vbl(); chk("nav_up", 1, 0, 0, 0, 0);

    // Car select with wrap in both directions
    press(2); vbl(); chk("car_enter", 3, 0, 0, 0, 0);
    press(0);        chk("car_down_wrap", 3, 3, 0, 0, 0);
    press(1);        chk("car_up_wrap", 3, 0, 0, 0, 0);
    press(0);        chk("car_down_again", 3, 3, 0, 0, 0);
    press(2); vbl(); chk("car_exit", 1, 3, 0, 0, 0);
    press(1); vbl(); chk("back_main_play", 0, 3, 0, 0, 0);

    // Countdown to race start
    press(2);        chk("cd_load", 0, 3, 3, 0, 0);
    countdown_run(3, 0);
    vbl();           chk("in_game_shown", 6, 3, 0, 0, 1);

    // race_done and esc together: race_done wins
    race_done = 1'b1; key_esc = 1'b1;
    tick();
    race_done = 1'b0; key_esc = 1'b0;
    tick();
    vbl();           chk("result_shown", 7, 3, 0, 0, 1);
    press(2); vbl(); chk("result_exit", 0, 3, 0, 0, 1);

    // Abort at digit 2 with esc and up in the same cycle
    press(2);        chk("abort_load", 0, 3, 3, 0, 1);
    vbl(); vbl();    chk("abort_digit2", 5, 3, 2, 0, 1);
    key_esc = 1'b1; key_up = 1'b1;
    tick();
    key_esc = 1'b0; key_up = 1'b0;
    tick();
    chk("abort_cd_zero", 5, 3, 0, 0, 1);
    vbl();           chk("abort_main_play", 0, 3, 0, 0, 1);
    vbl(); vbl(); vbl(); vbl();
    chk("abort_no_pulse", 0, 3, 0, 0, 1);

    // Frame latch: two moves between vblank edges
    press(0);        chk("latch_hold1", 0, 3, 0, 0, 1);
    press(0);        chk("latch_hold2", 0, 3, 0, 0, 1);
    vbl();           chk("latch_jump", 2, 3, 0, 0, 1);
    press(0); vbl(); chk("latch_back", 0, 3, 0, 0, 1);

    // enter beats down in the same cycle
    key_enter = 1'b1; key_down = 1'b1;
    tick();
    key_enter = 1'b0; key_down = 1'b0;
    tick();
    chk("prio_enter_down", 0, 3, 3, 0, 1);
    press(3); vbl(); chk("prio_abort", 0, 3, 0, 0, 1);

    // key_enter held through reset release
    rst = 1'b1; key_enter = 1'b1;
    tick();
    chk("reset_again", 0, 0, 0, 0, 1);
    rst = 1'b0;
    tick(); tick(); tick();
    chk("held_enter_no_press", 0, 0, 0, 0, 1);
    vbl();           chk("held_enter_ms", 0, 0, 0, 0, 1);
    key_enter = 1'b0;
    tick();

    // race_done outside IN_GAME is ignored
    race_done = 1'b1;
    tick();
    race_done = 1'b0;
    tick();
    vbl();           chk("race_done_ignored", 0, 0, 0, 0, 1);

    // Second race, then reset mid-race
    press(2);        chk("cd2_load", 0, 0, 3, 0, 1);
    countdown_run(0, 1);
    vbl();           chk("in_game2_shown", 6, 0, 0, 0, 2);
    rst = 1'b1;
    #1;
    tick();
    chk("rst_mid_race", 0, 0, 0, 0, 2);
    rst = 1'b0;
    tick(); tick();

    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/menu_control.md
MENU_CONTROL -- requirements
Module: menu_control

Interface
REQ-001 Parameter: FRAMES_PER_COUNT, default 60, number of vblank periods per countdown digit (legal range 1..255).
REQ-002 clk  input  1  pixel clock shared with the VGA pipeline.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 key_up, key_down, key_enter, key_esc  input  1 each  level-held key flags from the keyboard decoder, synchronous to clk.
REQ-005 vblnk_in  input  1  vertical blank from the timing generator.
REQ-006 race_done  input  1  single-cycle pulse from the race engine when the race finishes.
REQ-007 menu_state  output  3  screen code for the menu text overlay stage.
REQ-008 car_sel  output  2  selected car index.
REQ-009 countdown  output  2  digit shown during countdown (3,2,1); 0 otherwise.
REQ-010 race_start  output  1  single-cycle pulse to the race engine.

Function
REQ-011 Key press = rising edge of the key level, detected with one register stage per key; a key held high produces exactly one press.
REQ-012 Multiple presses in the same cycle: only the highest-priority one acts, priority esc > enter > up > down; the rest are dropped.
REQ-013 Internal state S uses the menu_state encoding: 0 MAIN_PLAY, 1 MAIN_CARS, 2 MAIN_HELP, 3 CAR_SELECT, 4 HELP_SCREEN, 5 COUNTDOWN, 6 IN_GAME, 7 RESULT.
REQ-014 S updates on the clk edge following the cycle in which the press is detected (one-cycle latency from key edge to S).
REQ-015 MAIN_PLAY: down->MAIN_CARS, up->MAIN_HELP, enter->COUNTDOWN.
REQ-016 MAIN_CARS: down->MAIN_HELP, up->MAIN_PLAY, enter->CAR_SELECT.
REQ-017 MAIN_HELP: down->MAIN_PLAY, up->MAIN_CARS, enter->HELP_SCREEN.
REQ-018 CAR_SELECT: up increments car_sel mod 4 (3 wraps to 0), down decrements mod 4 (0 wraps to 3); enter or esc->MAIN_CARS, car_sel retained.
REQ-019 HELP_SCREEN: enter or esc->MAIN_HELP.
REQ-020 COUNTDOWN entry: countdown loads 3, frame counter loads 0.
REQ-021 Vblank edge = vblnk_in high with its registered copy low.
REQ-022 In COUNTDOWN, each vblank edge increments the frame counter; at FRAMES_PER_COUNT-1 it wraps to 0 and countdown decrements.
REQ-023 When countdown is 1 and the frame counter wraps: S->IN_GAME, countdown->0, race_start high for exactly that one cycle.
REQ-024 esc in COUNTDOWN aborts to MAIN_PLAY, countdown->0, no race_start.
REQ-025 Other keys in COUNTDOWN are ignored.
REQ-026 IN_GAME: race_done->RESULT; esc->MAIN_PLAY; if race_done and an esc press coincide, race_done wins.
REQ-027 RESULT: enter or esc->MAIN_PLAY.
REQ-028 race_done outside IN_GAME is ignored.
REQ-029 Keys not listed for the current state are ignored.
REQ-030 menu_state is a shadow of S, loaded only on the clk edge of a detected vblank edge, so the overlay never changes screen mid-frame; S changes between vblank edges appear one frame late; only the latest S is published.
REQ-031 car_sel, countdown and race_start are driven directly from internal registers, not frame-latched.

Reset
REQ-032 On rst: S=MAIN_PLAY, menu_state=0, car_sel=0, countdown=0, race_start=0, frame counter=0, vblnk register=1.
REQ-033 Key-edge registers reset to 1, so a key held through reset release produces no press until released and pressed again.
REQ-034 rst asserted mid-countdown or mid-race returns everything to the reset values immediately, with no race_start pulse.

Verification (FRAMES_PER_COUNT=2)
REQ-035 Navigation: reset, press down twice, then up once, each followed by a vblank edge -> menu_state 1, 2, 1.
REQ-036 Car select: from MAIN_CARS press enter, then down, then enter; vblank edges between presses -> car_sel 3, menu_state 3 then 1.
REQ-037 Countdown: enter in MAIN_PLAY, then 6 vblank edges -> countdown 3,3,2,2,1,1 then 0; race_start high exactly 1 cycle; menu_state 6 after the next vblank edge.
REQ-038 Abort and priority: enter at COUNTDOWN digit 2, then esc and up pressed in the same cycle -> S=MAIN_PLAY, countdown 0, no race_start.
REQ-039 Frame latch: two presses between vblank edges (down, down) -> menu_state jumps 0->2 at the next vblank edge, never shows 1.
REQ-040 Reset corners: key_enter held through rst release -> no transition; race_done while in MAIN_PLAY -> ignored; rst mid-race -> all outputs 0.
